demux_1_4_reg: RTL

- Registered 1:4 demultiplexer with valid/ready handshakes on every side; the distributing counterpart of the core's 4:1 select muxes.
- Routes one producer stream (e.g. writeback/result bus) to one of four consumers selected per transfer.
- Contains a one-entry holding register that sustains full throughput.
- Contains per-channel wrapping transfer counters for debug and performance visibility.

---
 rtl/demux_1_4_reg_pkg.sv | 30 +++
 rtl/demux_chan_counter.sv | 23 ++
 rtl/demux_1_4_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/demux_1_4_reg_pkg.sv
// Shared constants for the registered 1:4 demultiplexer.
package demux_1_4_reg_pkg;

    // Holding-register state encoding
    localparam logic DEMUX_STATE_EMPTY = 1'b0;
    localparam logic DEMUX_STATE_FULL  = 1'b1;

    // Channel indices
    localparam logic [1:0] DEMUX_CH0 = 2'd0;
    localparam logic [1:0] DEMUX_CH1 = 2'd1;
    localparam logic [1:0] DEMUX_CH2 = 2'd2;
    localparam logic [1:0] DEMUX_CH3 = 2'd3;

    localparam int DEMUX_NUM_CH = 4;

    // One-hot decode of a channel index, bit k set for channel k
    function automatic logic [DEMUX_NUM_CH-1:0] demux_sel_onehot(input logic [1:0] sel);
        logic [DEMUX_NUM_CH-1:0] onehot;
        onehot = '0;
        case (sel)
            DEMUX_CH0: onehot = 4'b0001;
            DEMUX_CH1: onehot = 4'b0010;
            DEMUX_CH2: onehot = 4'b0100;
            DEMUX_CH3: onehot = 4'b1000;
            default:   onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux_chan_counter.sv
// Per-channel transfer counter: wraps silently, clear wins over increment.
module demux_chan_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] count
);

    // Count handoffs; synchronous clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 demultiplexer with a one-entry holding register.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no word held; producer is always accepted
// FULL  | word+sel held; Valid asserted on the held channel only; a new
//       | word is accepted only in a cycle where that channel takes it
module demux_1_4_reg
    import demux_1_4_reg_pkg::*;
#(
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         DEMUX_CLOCK_50,
    input  logic                         DEMUX_RESET_InLow,
    input  logic [OUTPUT_DATA_WIDTH-1:0] DEMUX_Input_InBUS,
    input  logic [1:0]                   DEMUX_Sel_InBUS,
    input  logic                         DEMUX_Valid_In,
    output logic                         DEMUX_Ready_Out,
    output logic [OUTPUT_DATA_WIDTH-1:0] DEMUX_Output_0_OutBUS,
    output logic [OUTPUT_DATA_WIDTH-1:0] DEMUX_Output_1_OutBUS,
    output logic [OUTPUT_DATA_WIDTH-1:0] DEMUX_Output_2_OutBUS,
    output logic [OUTPUT_DATA_WIDTH-1:0] DEMUX_Output_3_OutBUS,
    output logic                         DEMUX_Valid_0_Out,
    output logic                         DEMUX_Valid_1_Out,
    output logic                         DEMUX_Valid_2_Out,
    output logic                         DEMUX_Valid_3_Out,
    input  logic                         DEMUX_Ready_0_In,
    input  logic                         DEMUX_Ready_1_In,
    input  logic                         DEMUX_Ready_2_In,
    input  logic                         DEMUX_Ready_3_In,
    input  logic                         DEMUX_CountClr_In,
    output logic [COUNT_WIDTH-1:0]       DEMUX_Count_0_OutBUS,
    output logic [COUNT_WIDTH-1:0]       DEMUX_Count_1_OutBUS,
    output logic [COUNT_WIDTH-1:0]       DEMUX_Count_2_OutBUS,
    output logic [COUNT_WIDTH-1:0]       DEMUX_Count_3_OutBUS
);

    logic                         state_q;
    logic [OUTPUT_DATA_WIDTH-1:0] data_q;
    logic [1:0]                   sel_q;

    logic [DEMUX_NUM_CH-1:0]      ready_ch;
    logic [DEMUX_NUM_CH-1:0]      sel_onehot;
    logic [DEMUX_NUM_CH-1:0]      valid_ch;
    logic [DEMUX_NUM_CH-1:0]      deliver_ch;
    logic                         handoff;
    logic                         accept;

    assign ready_ch = {DEMUX_Ready_3_In, DEMUX_Ready_2_In, DEMUX_Ready_1_In, DEMUX_Ready_0_In};

    // Decode the held channel into per-channel valid and delivery strobes
    always_comb begin
        sel_onehot = demux_sel_onehot(sel_q);
        valid_ch   = '0;
        if (state_q == DEMUX_STATE_FULL) begin
            valid_ch = sel_onehot;
        end
        // Ready of non-selected channels is masked off here
        deliver_ch = valid_ch & ready_ch;
        handoff    = |deliver_ch;
        // Selected consumer's ready passes straight through to the producer
        DEMUX_Ready_Out = (state_q == DEMUX_STATE_EMPTY) || handoff;
        accept          = DEMUX_Valid_In && DEMUX_Ready_Out;
    end

    // Holding register and EMPTY/FULL state
    always_ff @(posedge DEMUX_CLOCK_50 or negedge DEMUX_RESET_InLow) begin
        if (!DEMUX_RESET_InLow) begin
            state_q <= DEMUX_STATE_EMPTY;
            data_q  <= '0;
            sel_q   <= DEMUX_CH0;
        end else if (accept) begin
            state_q <= DEMUX_STATE_FULL;
            data_q  <= DEMUX_Input_InBUS;
            sel_q   <= DEMUX_Sel_InBUS;
        end else if (handoff) begin
            state_q <= DEMUX_STATE_EMPTY;
        end
    end

    assign DEMUX_Valid_0_Out = valid_ch[0];
    assign DEMUX_Valid_1_Out = valid_ch[1];
    assign DEMUX_Valid_2_Out = valid_ch[2];
    assign DEMUX_Valid_3_Out = valid_ch[3];

    // All channels see the holding register; consumers qualify with valid
    assign DEMUX_Output_0_OutBUS = data_q;
    assign DEMUX_Output_1_OutBUS = data_q;
    assign DEMUX_Output_2_OutBUS = data_q;
    assign DEMUX_Output_3_OutBUS = data_q;

    demux_chan_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_count_0 (
        .clk   (DEMUX_CLOCK_50),
        .rst_n (DEMUX_RESET_InLow),
        .inc   (deliver_ch[0]),
        .clr   (DEMUX_CountClr_In),
        .count (DEMUX_Count_0_OutBUS)
    );

    demux_chan_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_count_1 (
        .clk   (DEMUX_CLOCK_50),
        .rst_n (DEMUX_RESET_InLow),
        .inc   (deliver_ch[1]),
        .clr   (DEMUX_CountClr_In),
        .count (DEMUX_Count_1_OutBUS)
    );

    demux_chan_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_count_2 (
        .clk   (DEMUX_CLOCK_50),
        .rst_n (DEMUX_RESET_InLow),
        .inc   (deliver_ch[2]),
        .clr   (DEMUX_CountClr_In),
        .count (DEMUX_Count_2_OutBUS)
    );

    demux_chan_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_count_3 (
        .clk   (DEMUX_CLOCK_50),
        .rst_n (DEMUX_RESET_InLow),
        .inc   (deliver_ch[3]),
        .clr   (DEMUX_CountClr_In),
        .count (DEMUX_Count_3_OutBUS)
    );

endmodule
